// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array driver: controller states and
// the watchdog limit used while waiting on the array frame.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    COLLECT,
    DONE
  } state_t;

  // Cycles allowed in DRAIN plus COLLECT before the run is abandoned.
  function automatic int wd_limit(input int n);
    return 4 * n + 8;
  endfunction

endpackage

// File: rtl/row_buffer.sv
// Row-addressed register file: one synchronous write port and one
// combinational read port; contents clear on reset.
module row_buffer #(
  parameter int ROWS  = 2,
  parameter int WIDTH = 64,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROWS];

  // NOTE: the whole array is reset because the host may read results before any run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/systolic_array_driver.sv
// Host-side controller for a systolic array frame: buffers operands, streams
// weight then data rows, waits for the frame, and collects result rows.
module systolic_array_driver
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  localparam int AW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
  localparam int RW = MATRIX_SIZE * DATA_SIZE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_row,
  input  logic [RW-1:0] wr_data,
  input  logic [AW-1:0] rd_row,
  output logic [RW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [RW-1:0] data_input,
  output logic [RW-1:0] weights_input,
  output logic          enable,
  output logic          input_ready,
  output logic          output_ready,
  input  logic          module_ready,
  input  logic          finished,
  input  logic [RW-1:0] result_out
);

  localparam int CW       = AW + 1;
  localparam int WD_LIMIT = wd_limit(MATRIX_SIZE);
  localparam int WW       = $clog2(WD_LIMIT + 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(MATRIX_SIZE - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WD_LIMIT - 1);

  state_t        state, state_next;
  logic [CW-1:0] row_cnt, row_cnt_next;
  logic [WW-1:0] wd_cnt, wd_cnt_next;
  logic          timeout_err_next;
  logic          host_win, start_ok, wd_expired, row_adv;
  logic          data_we, weight_we, result_we;
  logic [RW-1:0] data_row, weight_row;

  assign host_win   = (state == IDLE) || (state == DONE);
  assign start_ok   = host_win && start && module_ready;
  assign data_we    = host_win && wr_en && !wr_sel;
  assign weight_we  = host_win && wr_en && wr_sel;
  assign result_we  = (state == COLLECT) && finished;
  assign wd_expired = ((state == DRAIN) || (state == COLLECT)) && (wd_cnt == WD_LAST);

  row_buffer #(.ROWS(MATRIX_SIZE), .WIDTH(RW), .AW(AW)) u_data_buf (
    .clk(clk), .reset(reset), .we(data_we), .waddr(wr_row), .wdata(wr_data),
    .raddr(row_cnt[AW-1:0]), .rdata(data_row)
  );

  row_buffer #(.ROWS(MATRIX_SIZE), .WIDTH(RW), .AW(AW)) u_weight_buf (
    .clk(clk), .reset(reset), .we(weight_we), .waddr(wr_row), .wdata(wr_data),
    .raddr(row_cnt[AW-1:0]), .rdata(weight_row)
  );

  row_buffer #(.ROWS(MATRIX_SIZE), .WIDTH(RW), .AW(AW)) u_result_buf (
    .clk(clk), .reset(reset), .we(result_we), .waddr(row_cnt[AW-1:0]), .wdata(result_out),
    .raddr(rd_row), .rdata(rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      row_cnt     <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      row_cnt     <= row_cnt_next;
      wd_cnt      <= wd_cnt_next;
      timeout_err <= timeout_err_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next    = state;
    row_adv       = 1'b0;
    wd_cnt_next   = '0;
    busy          = 1'b0;
    done          = 1'b0;
    enable        = 1'b0;
    input_ready   = 1'b0;
    output_ready  = 1'b0;
    data_input    = '0;
    weights_input = '0;

    case (state)
      IDLE: begin
        if (start_ok) state_next = LOAD_W;
      end
      LOAD_W: begin
        {busy, enable, input_ready, output_ready} = 4'b1111;
        weights_input = weight_row;
        row_adv       = 1'b1;
        if (row_cnt == LAST_ROW) state_next = STREAM;
      end
      STREAM: begin
        {busy, enable, input_ready, output_ready} = 4'b1111;
        data_input = data_row;
        row_adv    = 1'b1;
        if (row_cnt == LAST_ROW) state_next = DRAIN;
      end
      DRAIN: begin
        {busy, enable, input_ready, output_ready} = 4'b1111;
        wd_cnt_next = wd_expired ? '0 : wd_cnt + WW'(1);
        if (wd_expired)    state_next = IDLE;
        else if (finished) state_next = COLLECT;
      end
      COLLECT: begin
        busy         = 1'b1;
        output_ready = 1'b1;
        row_adv      = finished;
        wd_cnt_next  = wd_expired ? '0 : wd_cnt + WW'(1);
        if (wd_expired)                              state_next = IDLE;
        else if (finished && (row_cnt == LAST_ROW)) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start_ok)   state_next = LOAD_W;
        else if (wr_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Row counter restarts on each state entry and saturates rather than wrapping.
    if (state_next != state)                 row_cnt_next = '0;
    else if (row_adv && (row_cnt != '1))     row_cnt_next = row_cnt + CW'(1);
    else                                     row_cnt_next = row_cnt;

    if (start_ok)        timeout_err_next = 1'b0;
    else if (wd_expired) timeout_err_next = 1'b1;
    else                 timeout_err_next = timeout_err;
  end

endmodule

// File: tb/tb_systolic_array_driver.sv
// Directed bench for systolic_array_driver with a behavioural array frame and
// a result scoreboard fed by the stimulus and drained when done rises.
module tb_systolic_array_driver;

  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int AW  = 1;
  localparam int RW  = N * DW;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [AW-1:0] wr_row = '0;
  logic [RW-1:0] wr_data = '0;
  logic [AW-1:0] rd_row = '0;
  logic [RW-1:0] rd_data;
  logic          busy, done, timeout_err;
  logic [RW-1:0] data_input, weights_input;
  logic          enable, input_ready, output_ready;
  logic          module_ready = 1'b0;
  logic          finished = 1'b0;
  logic [RW-1:0] result_out = '0;

  always #5 clk = ~clk;

  systolic_array_driver #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_data(wr_data),
    .rd_row(rd_row), .rd_data(rd_data),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .data_input(data_input), .weights_input(weights_input),
    .enable(enable), .input_ready(input_ready), .output_ready(output_ready),
    .module_ready(module_ready), .finished(finished), .result_out(result_out)
  );

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] exp_q[$];
  bit            frame_hang = 1'b0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] row2(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    return {e1, e0};
  endfunction

  // Array frame model: first N enabled cycles carry weights, next N data,
  // then it signals finished after LAT drain cycles and returns D x W by rows.
  logic [DW-1:0] fw[N][N];
  logic [DW-1:0] fd[N][N];
  int            ecount = 0;
  int            kout = 0;

  always @(negedge clk) begin
    if (!reset) begin
      ecount = 0; kout = 0; finished = 1'b0; result_out = '0;
    end else if (enable) begin
      for (int j = 0; j < N; j++) begin
        if (ecount < N)          fw[ecount][j]     = weights_input[j*DW +: DW];
        else if (ecount < 2 * N) fd[ecount - N][j] = data_input[j*DW +: DW];
      end
      finished   = !frame_hang && (ecount == 2 * N + LAT);
      result_out = '0;
      ecount++;
    end else if (output_ready) begin
      finished = 1'b1;
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) acc += fd[kout % N][k] * fw[k][j];
        result_out[j*DW +: DW] = acc;
      end
      kout++;
    end else begin
      ecount = 0; kout = 0; finished = 1'b0; result_out = '0;
    end
  end

  // Monitor: when done rises, read every result row and compare with the queue.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (reset && done && !done_q) begin
      for (int r = 0; r < N; r++) begin
        rd_row = AW'(r);
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: result row %0d with no expected value, got %0h", r, rd_data);
        end else begin
          check($sformatf("result row %0d", r), rd_data, exp_q.pop_front());
        end
      end
    end
    done_q = done;
  end

  task automatic write_row(input logic sel, input logic [AW-1:0] r,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    wr_en = 1'b1; wr_sel = sel; wr_row = r; wr_data = row2(e0, e1);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("done reached", done, 1'b1);
  endtask

  task automatic fire_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " enable"}, enable, 1'b0);
    check({tag, " input_ready"}, input_ready, 1'b0);
    check({tag, " output_ready"}, output_ready, 1'b0);
    check({tag, " data_input"}, data_input, '0);
    check({tag, " weights_input"}, weights_input, '0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset done", done, 1'b0);
    check("reset timeout_err", timeout_err, 1'b0);
    check("reset rd_data", rd_data, '0);
    reset = 1'b1;
    @(negedge clk);

    // Start while the frame is not ready: ignored and not remembered.
    start = 1'b1; module_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("not ready");
    end
    start = 1'b0; module_ready = 1'b1;
    @(negedge clk);
    check("start not latched busy", busy, 1'b0);

    // Basic multiply with cycle-exact streaming.
    write_row(1'b0, 1'b0, 1, 2);
    write_row(1'b0, 1'b1, 3, 4);
    write_row(1'b1, 1'b0, 5, 6);
    write_row(1'b1, 1'b1, 7, 8);
    exp_q.push_back(row2(19, 22));
    exp_q.push_back(row2(43, 50));
    fire_start();
    check("c1 weights row0", weights_input, row2(5, 6));
    check("c1 data zero", data_input, '0);
    check("c1 enable", enable, 1'b1);
    check("c1 busy", busy, 1'b1);
    @(negedge clk);
    check("c2 weights row1", weights_input, row2(7, 8));
    @(negedge clk);
    check("c3 data row0", data_input, row2(1, 2));
    check("c3 weights zero", weights_input, '0);
    @(negedge clk);
    check("c4 data row1", data_input, row2(3, 4));
    @(negedge clk);
    check("c5 drain data zero", data_input, '0);
    check("c5 drain enable", enable, 1'b1);
    check("c5 drain output_ready", output_ready, 1'b1);
    wait_done(40);
    check("run1 busy low", busy, 1'b0);
    @(negedge clk);
    check("run1 scoreboard empty", RW'(exp_q.size()), '0);

    // Write and start together in DONE: the new data row is used.
    exp_q.push_back(row2(10, 12));
    exp_q.push_back(row2(43, 50));
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b0; wr_data = row2(2, 0);
    start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    check("write+start enters LOAD_W", enable, 1'b1);
    wait_done(40);
    @(negedge clk);
    check("run2 scoreboard empty", RW'(exp_q.size()), '0);

    // Frame never finishes: watchdog fires after 16 drain cycles.
    frame_hang = 1'b1;
    fire_start();
    repeat (19) @(negedge clk);
    check("c20 timeout_err still low", timeout_err, 1'b0);
    check("c20 still busy", busy, 1'b1);
    @(negedge clk);
    check("c21 timeout_err", timeout_err, 1'b1);
    check_idle_outputs("after timeout");
    check("after timeout done", done, 1'b0);
    start = 1'b1; module_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("timeout_err sticky", timeout_err, 1'b1);
    start = 1'b0; module_ready = 1'b1;
    frame_hang = 1'b0;
    check("result kept after timeout", rd_data, row2(43, 50));

    // Normal run clears the sticky flag; a write while busy is ignored.
    exp_q.push_back(row2(10, 12));
    exp_q.push_back(row2(43, 50));
    fire_start();
    check("timeout_err cleared on start", timeout_err, 1'b0);
    write_row(1'b0, 1'b1, 9, 9);
    wait_done(40);
    @(negedge clk);
    check("run3 scoreboard empty", RW'(exp_q.size()), '0);

    // Reset in STREAM row 1 aborts at once, then a fresh run completes.
    fire_start();
    repeat (3) @(negedge clk);
    check("c4 before reset data row1", data_input, row2(3, 4));
    reset = 1'b0;
    #1;
    check_idle_outputs("mid reset");
    check("mid reset done", done, 1'b0);
    check("mid reset rd_data", rd_data, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    write_row(1'b0, 1'b0, 1, 2);
    write_row(1'b0, 1'b1, 3, 4);
    write_row(1'b1, 1'b0, 5, 6);
    write_row(1'b1, 1'b1, 7, 8);
    exp_q.push_back(row2(19, 22));
    exp_q.push_back(row2(43, 50));
    fire_start();
    wait_done(40);
    @(negedge clk);
    check("run4 scoreboard empty", RW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global time limit: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
